// File: rtl/phase_rate_decoder_pkg.sv
// phase_rate_decoder_pkg
// Shared definitions for the phase-rate decoder: FSM state encoding,
// default widths and the measurement-window length helper.
package phase_rate_decoder_pkg;

  localparam int unsigned PRD_PHASE_W_DEF = 8;
  localparam int unsigned PRD_FRAC_W_DEF  = 8;

  typedef enum logic [1:0] {
    IDLE,
    MEASURE,
    HOLD
  } prd_state_e;

  // The number of cycles in one measurement window. Over exactly this many
  // cycles the fractional bits of the remote accumulator complete a full
  // revolution, so the observed byte advances by exactly the increment.
  function automatic int unsigned window_len(input int unsigned frac_w);
    return 32'd1 << frac_w;
  endfunction

endpackage

// File: rtl/phase_rate_decoder_if.sv
// phase_rate_decoder_if
// Bundles the observed phase byte, the control inputs and the
// valid/ready result port of the phase-rate decoder.
//   master : the consumer/environment side (drives phase_in, start,
//            continuous, inc_ready; observes results and status)
//   slave  : the decoder side
interface phase_rate_decoder_if #(
  parameter int unsigned PHASE_W = 8
);
  logic [PHASE_W-1:0] phase_in;
  logic               start;
  logic               continuous;
  logic [PHASE_W-1:0] inc_out;
  logic               inc_valid;
  logic               inc_ready;
  logic               busy;
  logic               overrun;
  logic               locked;

  modport master (
    output phase_in, start, continuous, inc_ready,
    input  inc_out, inc_valid, busy, overrun, locked
  );

  modport slave (
    input  phase_in, start, continuous, inc_ready,
    output inc_out, inc_valid, busy, overrun, locked
  );
endinterface

// File: rtl/phase_rate_decoder_window_timer.sv
// window_timer
// FRAC_W-bit free-running window counter with synchronous clear.
//   clk, rst_n : clock, synchronous active-low reset
//   clear      : force the count to zero on the next edge
//   en         : count this cycle
//   tc         : single-cycle pulse during the 2^FRAC_W-th counted cycle,
//                i.e. the edge that closes the window
module window_timer
  import phase_rate_decoder_pkg::*;
#(
  parameter int unsigned FRAC_W = PRD_FRAC_W_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic en,
  output logic tc
);

  localparam int unsigned      WLEN = window_len(FRAC_W);
  localparam logic [FRAC_W-1:0] LAST = FRAC_W'(WLEN - 1);

  logic [FRAC_W-1:0] count;

  // The counter wraps from LAST to zero on the terminal edge, which is what
  // lets back-to-back windows run without an explicit clear.
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      count <= '0;
    end else if (en) begin
      count <= count + FRAC_W'(1);
    end
  end

  assign tc = en && (count == LAST);

endmodule

// File: rtl/phase_rate_decoder.sv
// phase_rate_decoder
// Recovers the per-cycle increment of a remote phase accumulator from its
// exported upper byte by measuring the byte's advance over 2^FRAC_W cycles.
//   clk, rst_n : clock, synchronous active-low reset
//   bus.phase_in   : observed upper byte of the remote accumulator
//   bus.start      : begin a measurement (sampled only in IDLE)
//   bus.continuous : run windows back-to-back
//   bus.inc_out/inc_valid/inc_ready : result valid/ready port
//   bus.busy       : measuring
//   bus.overrun    : sticky, an unaccepted result was overwritten
//   bus.locked     : last two results matched
// Optional feature macro: PRD_LOCK_EN enables the lock comparator; without
// it, locked is tied low.
module phase_rate_decoder
  import phase_rate_decoder_pkg::*;
#(
  parameter int unsigned PHASE_W = PRD_PHASE_W_DEF,
  parameter int unsigned FRAC_W  = PRD_FRAC_W_DEF
) (
  input logic                 clk,
  input logic                 rst_n,
  phase_rate_decoder_if.slave bus
);

  prd_state_e         state;
  logic [PHASE_W-1:0] snap_a;
  logic [PHASE_W-1:0] inc_out_q;
  logic [PHASE_W-1:0] diff;
  logic               inc_valid_q;
  logic               busy_q;
  logic               overrun_q;
  logic               win_clear;
  logic               win_en;
  logic               win_end;

`ifdef PRD_LOCK_EN
  logic [PHASE_W-1:0] prev_res;
  logic               have_prev;
  logic               locked_q;
`endif

  assign win_clear = (state == IDLE) && bus.start;
  assign win_en    = (state == MEASURE);
  assign diff      = bus.phase_in - snap_a;

  window_timer #(
    .FRAC_W(FRAC_W)
  ) u_window_timer (
    .clk  (clk),
    .rst_n(rst_n),
    .clear(win_clear),
    .en   (win_en),
    .tc   (win_end)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      snap_a      <= '0;
      inc_out_q   <= '0;
      inc_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef PRD_LOCK_EN
      prev_res    <= '0;
      have_prev   <= 1'b0;
      locked_q    <= 1'b0;
`endif
    end else begin
      // Acceptance applies in every state; a new result written below on
      // the same edge takes precedence.
      if (inc_valid_q && bus.inc_ready) begin
        inc_valid_q <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (bus.start) begin
            snap_a    <= bus.phase_in;
            overrun_q <= 1'b0;
            busy_q    <= 1'b1;
            state     <= MEASURE;
`ifdef PRD_LOCK_EN
            have_prev <= 1'b0;
            locked_q  <= 1'b0;
`endif
          end
        end

        MEASURE: begin
          if (win_end) begin
            inc_out_q   <= diff;
            inc_valid_q <= 1'b1;
            snap_a      <= bus.phase_in;
            // Accepting on the overwrite edge consumes the old value.
            if (inc_valid_q && !bus.inc_ready) begin
              overrun_q <= 1'b1;
            end
`ifdef PRD_LOCK_EN
            if (have_prev) begin
              locked_q <= (diff == prev_res);
            end
            prev_res  <= diff;
            have_prev <= 1'b1;
`endif
            if (!bus.continuous) begin
              busy_q <= 1'b0;
              state  <= HOLD;
            end
          end
        end

        HOLD: begin
          if (bus.inc_ready) begin
            state <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.inc_out   = inc_out_q;
  assign bus.inc_valid = inc_valid_q;
  assign bus.busy      = busy_q;
  assign bus.overrun   = overrun_q;
`ifdef PRD_LOCK_EN
  assign bus.locked    = locked_q;
`else
  assign bus.locked    = 1'b0;
`endif

endmodule

// File: doc/phase_rate_decoder.md
# phase_rate_decoder

Recovers the per-cycle increment of a 16-bit phase accumulator by observing only the accumulator's exported upper byte. It measures how far that byte advances over a window of 2^FRAC_W cycles. Because the accumulator carries FRAC_W fractional bits, that advance equals the increment exactly, modulo 2^PHASE_W. The block sits on the receive side of the accumulator's `uo_out` bus, in the same clock domain, and returns the recovered value through a valid/ready result port.

## Interface
- `PHASE_W`, default 8: width of the observed phase byte and of the result.
- `FRAC_W`, default 8: fractional bits below the observed byte. The measurement window is 2^FRAC_W cycles.
- `clk`  in  1: clock. All state changes on its rising edge.
- `rst_n`  in  1: reset, synchronous, active-low.
- `phase_in`  in  PHASE_W: upper byte of the remote accumulator, synchronous to `clk`.
- `start`  in  1: begins a measurement. Sampled only in IDLE.
- `continuous`  in  1: at each window end, start the next window back-to-back.
- `inc_out`  out  PHASE_W: recovered increment.
- `inc_valid`  out  1: `inc_out` holds an unaccepted result.
- `inc_ready`  in  1: consumer accepts the result.
- `busy`  out  1: high in MEASURE.
- `overrun`  out  1: sticky. A result was overwritten before it was accepted.
- `locked`  out  1: the last two results were equal. Tied 0 without `PRD_LOCK_EN`.

## Operation
- Reset: state IDLE. `inc_out`=0, `inc_valid`=0, `busy`=0, `overrun`=0, `locked`=0. Window counter and snapshot are 0.
- States: IDLE, MEASURE, HOLD.
- **IDLE**
  - When `start`=1: capture `snap_a` <= `phase_in`, clear the window counter, clear `overrun` and `locked`, go to MEASURE.
- **MEASURE**
  - The counter increments every cycle.
  - On the 2^FRAC_W-th edge after entry:
    - `inc_out` <= (`phase_in` − `snap_a`) mod 2^PHASE_W.
    - `inc_valid` <= 1.
    - `snap_a` <= `phase_in`.
  - Next state: if `continuous`=1, stay in MEASURE with the counter cleared, so there is no gap between windows. Otherwise go to HOLD.
- **HOLD**
  - Wait for `inc_ready`=1, then go to IDLE.
  - `start` is ignored in HOLD and in MEASURE.
- **Handshake**
  - A result is accepted on any edge where `inc_valid`=1 and `inc_ready`=1. `inc_valid` drops on that edge.
  - `inc_out` is stable while `inc_valid`=1, except on overwrite.
- **Overwrite**
  - In continuous mode a window can complete while `inc_valid`=1 and `inc_ready`=0.
  - The new value replaces `inc_out`, `inc_valid` stays 1, and `overrun` <= 1.
  - If `inc_ready`=1 on that same edge, the old value counts as accepted and `overrun` is not set.
- **Dropping `continuous` mid-window:** the current window completes normally, then the block goes to HOLD.
- **Arithmetic:** subtraction is PHASE_W bits and wraps. Every increment from 0 to 2^PHASE_W−1 is recovered exactly.
- **Reset mid-operation:** return to reset values on the next edge. A partial window produces no result.

## Timing
- `start` is sampled at edge t. `inc_valid` is high after edge t+2^FRAC_W. Default latency is 256 cycles.
- Continuous mode produces one result every 2^FRAC_W cycles.
- `busy` is high after edge t and low after the window-end edge in single-shot mode. It stays high in continuous mode.
- `phase_in` is used unregistered at the snapshot edges. The upstream accumulator register already provides the alignment.

## Configuration
- `PRD_LOCK_EN` defined:
  - A previous-result register is compared against each new result.
  - `locked` <= 1 when a completed result equals the previous one, and <= 0 on a mismatch.
  - `locked` is cleared on a `start` accepted in IDLE and on reset.
  - The first result after `start` never sets `locked`.
- `PRD_LOCK_EN` undefined: no compare logic. `locked` is tied 0.

## Structure
- Package `phase_rate_decoder_pkg` holds:
  - the state enum (IDLE, MEASURE, HOLD);
  - the default PHASE_W and FRAC_W localparams;
  - a function for the window length, 2^FRAC_W.
- One sub-module, `window_timer`:
  - clear input;
  - FRAC_W-bit counter;
  - single-cycle terminal pulse on the 2^FRAC_W-th cycle.

## Test plan
1. **Reset.** Hold `rst_n`=0 for 3 edges with random inputs. All outputs are 0 and the state is IDLE.
2. **Single-shot.** The bench models an accumulator (`acc` += 0x05, `phase_in`=`acc[15:8]`). Pulse `start`. `inc_valid` rises exactly 256 edges later with `inc_out`=0x05. It holds until `inc_ready` and then falls. `busy`=0.
3. **Extremes.** Run with increment 0xFF, expect `inc_out`=0xFF. Run with increment 0x00, expect 0x00. Run with increment 0x80, expect 0x80. Also run with `phase_in` wrapping mid-window; the result must still be exact.
4. **Continuous overwrite.** Continuous mode, increment 0x10, `inc_ready`=0 for 2 windows. Expect `inc_out`=0x10 and `overrun`=1. Then `inc_ready`=1 for one edge: `inc_valid` falls and `overrun` stays 1 until the next `start`.
5. **Lock (with `PRD_LOCK_EN`).** Continuous mode, increment 0x20 for 3 windows: `locked`=1 after the 2nd result. Change to 0x21: `locked`=0 after the next result, then 1 after the result following it.
6. **Abort and ignore.** A `start` issued at cycle 50 of MEASURE is ignored; the result is still delivered at 256 cycles. `rst_n`=0 at cycle 100 of a window: the block returns to IDLE and no `inc_valid` appears.
